ram_access_master: RTL and testbench

RAM_ACCESS_MASTER -- requirements
Module: ram_access_master

---
 rtl/ram_access_pkg.sv | 19 +
 rtl/rr_arbiter_2.sv | 21 ++
 rtl/ram_access_master.sv | 152 +++++++++++++++
 tb/tb_ram_access_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_pkg.sv
// Shared definitions for the RAM access master: state encoding,
// default widths and client identifiers.
package ram_access_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ERR_W_DEF  = 8;

    // Client identifiers double as the grant encoding.
    localparam logic CLI_A = 1'b0;
    localparam logic CLI_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        VERIFY = 2'd2,
        ACK    = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-client round-robin selector: on a tie the client that was not
// granted last wins; a lone requester always wins.
module rr_arbiter_2
    import ram_access_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    // Pure combinational pick; the caller decides when to sample it.
    always_comb begin
        grant = CLI_A;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = CLI_B;
        end
    end

endmodule

// File: rtl/ram_access_master.sv
// Arbitrates two clients onto a register RAM. Writes are read back and
// compared; mismatches pulse verify_err and bump a saturating counter.
// All RAM strobes are registered on the rising edge so they are stable
// when the RAM samples them on the falling edge.
module ram_access_master
    import ram_access_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ERR_W  = ERR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_di,
    output logic              ram_ce3,
    output logic              ram_we3,
    output logic [DATA_W-1:0] ram_di3,
    output logic              ram_ce2,
    input  logic [DATA_W-1:0] ram_do,
    input  logic [DATA_W-1:0] ram_do2,
    output logic              verify_err,
    output logic [ERR_W-1:0]  err_cnt
);

    state_t            state;
    logic              gnt;
    logic              last_gnt;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic              arb_grant;
    logic [DATA_W-1:0] rd_sel;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rr_arbiter_2 u_arb (
        .req        ({b_req, a_req}),
        .last_grant (last_gnt),
        .grant      (arb_grant)
    );

    // Read data comes from port 1 for client A, port 2 for client B.
    always_comb begin
        rd_sel = (gnt == CLI_B) ? ram_do2 : ram_do;
    end

    // Transaction sequencer: strobes, capture, compare and acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= CLI_A;
            last_gnt   <= CLI_B;
            lat_we     <= 1'b0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_di     <= '0;
            ram_ce3    <= 1'b0;
            ram_we3    <= 1'b0;
            ram_di3    <= '0;
            ram_ce2    <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            verify_err <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            err_cnt    <= '0;
        end else begin
            // Strobes and pulses are single-cycle unless re-asserted below.
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_ce3    <= 1'b0;
            ram_we3    <= 1'b0;
            ram_ce2    <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            verify_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        gnt      <= arb_grant;
                        last_gnt <= arb_grant;
                        state    <= ACCESS;
                        if (arb_grant == CLI_A) begin
                            lat_we    <= a_we;
                            lat_wdata <= a_wdata;
                            ram_ce    <= 1'b1;
                            ram_we    <= a_we;
                            ram_di    <= a_wdata;
                        end else begin
                            lat_we    <= b_we;
                            lat_wdata <= b_wdata;
                            if (b_we) begin
                                ram_ce3 <= 1'b1;
                                ram_we3 <= 1'b1;
                                ram_di3 <= b_wdata;
                            end else begin
                                ram_ce2 <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        // Read back what was just written, read enables only.
                        state <= VERIFY;
                        if (gnt == CLI_A) ram_ce  <= 1'b1;
                        else              ram_ce2 <= 1'b1;
                    end else begin
                        state <= ACK;
                        if (gnt == CLI_A) begin
                            a_rdata <= rd_sel;
                            a_ack   <= 1'b1;
                        end else begin
                            b_rdata <= rd_sel;
                            b_ack   <= 1'b1;
                        end
                    end
                end
                VERIFY: begin
                    state <= ACK;
                    if (gnt == CLI_A) begin
                        a_rdata <= rd_sel;
                        a_ack   <= 1'b1;
                    end else begin
                        b_rdata <= rd_sel;
                        b_ack   <= 1'b1;
                    end
                    if (rd_sel != lat_wdata) begin
                        verify_err <= 1'b1;
                        err_cnt    <= sat_inc(err_cnt);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_master.sv
// Bench for ram_access_master: a single-word RAM model written on the
// falling edge, fixed vectors, random traffic against a scalar memory
// model, and hand sequences for tie, saturation and reset corners.
module tb_ram_access_master;

    localparam int DW = 32;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_ce, ram_we, ram_ce3, ram_we3, ram_ce2;
    logic [DW-1:0] ram_di, ram_di3, ram_do, ram_do2;
    logic          verify_err;
    logic [EW-1:0] err_cnt;

    logic [DW-1:0] mem = '0;
    bit            force_bad = 1'b0;

    int            total = 0;
    int            passed = 0;
    logic [DW-1:0] model_mem;

    typedef struct {
        bit            cl;
        bit            we;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
    } vec_t;

    always #5 clk = ~clk;

    ram_access_master #(.DATA_W(DW), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ce3(ram_ce3), .ram_we3(ram_we3), .ram_di3(ram_di3),
        .ram_ce2(ram_ce2), .ram_do(ram_do), .ram_do2(ram_do2),
        .verify_err(verify_err), .err_cnt(err_cnt)
    );

    // RAM model: one register, written on the falling edge.
    always @(negedge clk) begin
        if (ram_ce && ram_we)   mem <= ram_di;
        if (ram_ce3 && ram_we3) mem <= ram_di3;
    end
    assign ram_do  = !ram_ce ? '0 : (force_bad ? 32'hDEAD_BEEF : mem);
    assign ram_do2 = ram_ce2 ? mem : '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Write strobes must never collide, nor appear without their enable.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("we_exclusive", 64'(ram_we && ram_we3), 64'd0);
            chk("we3_needs_ce3", 64'(ram_we3 && !ram_ce3), 64'd0);
        end
    end

    task automatic do_txn(input bit cl, input bit we, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_rd, input bit exp_err, input string nm);
        int         lat;
        bit         got;
        logic [4:0] acc_exp, ver_exp;
        acc_exp = (cl == 1'b0) ? {1'b1, we, 3'b000} : (we ? 5'b00110 : 5'b00001);
        ver_exp = (cl == 1'b0) ? 5'b10000 : 5'b00001;
        @(negedge clk);
        if (cl == 1'b0) begin a_req = 1'b1; a_we = we; a_wdata = wd; end
        else            begin b_req = 1'b1; b_we = we; b_wdata = wd; end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) chk({nm, " access_strobes"}, 64'({ram_ce, ram_we, ram_ce3, ram_we3, ram_ce2}), 64'(acc_exp));
            if (lat == 2 && we) chk({nm, " verify_strobes"}, 64'({ram_ce, ram_we, ram_ce3, ram_we3, ram_ce2}), 64'(ver_exp));
            if (a_ack || b_ack) got = 1'b1;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk({nm, " ack_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({nm, " latency"}, 64'(lat), we ? 64'd3 : 64'd2);
            chk({nm, " acks"}, 64'({a_ack, b_ack}), (cl == 1'b0) ? 64'b10 : 64'b01);
            chk({nm, " rdata"}, 64'((cl == 1'b0) ? a_rdata : b_rdata), 64'(exp_rd));
            chk({nm, " verify_err"}, 64'(verify_err), 64'(exp_err));
        end
        @(posedge clk); #1;
        chk({nm, " ack_one_cycle"}, 64'({a_ack, b_ack, verify_err}), 64'd0);
        chk({nm, " rdata_hold"}, 64'((cl == 1'b0) ? a_rdata : b_rdata), 64'(exp_rd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[8];
        int            order[$];
        int            edges;
        int            n_bad;
        int            exp_cnt;
        bit            cl, we;
        logic [DW-1:0] wd, er;

        rst = 1'b1;
        a_req = 0; a_we = 0; a_wdata = '0;
        b_req = 0; b_we = 0; b_wdata = '0;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_00A5, 32'h0000_00A5, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0,         32'h0000_00A5, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,         32'h1234_5678, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b0};

        // Reset values
        do_reset();
        chk("rst_strobes", 64'({ram_ce, ram_we, ram_ce3, ram_we3, ram_ce2}), 64'd0);
        chk("rst_di", 64'({ram_di, ram_di3}), 64'd0);
        chk("rst_pulses", 64'({a_ack, b_ack, verify_err}), 64'd0);
        chk("rst_rdata", 64'({a_rdata, b_rdata}), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);

        // Tie from reset: A first, then B; B's write lands last
        @(negedge clk);
        a_req = 1; a_we = 1; a_wdata = 32'h1111_1111;
        b_req = 1; b_we = 1; b_wdata = 32'h2222_2222;
        edges = 0;
        while (order.size() < 2 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (a_ack) begin order.push_back(0); a_req = 0; end
            if (b_ack) begin order.push_back(1); b_req = 0; end
        end
        a_req = 0; b_req = 0;
        @(posedge clk); #1;
        chk("tie_both_acked", 64'(order.size()), 64'd2);
        if (order.size() == 2) begin
            chk("tie_first_A", 64'(order[0]), 64'd0);
            chk("tie_second_B", 64'(order[1]), 64'd1);
        end
        chk("tie_ram_final", 64'(mem), 64'h2222_2222);
        chk("tie_a_rdata", 64'(a_rdata), 64'h1111_1111);
        chk("tie_b_rdata", 64'(b_rdata), 64'h2222_2222);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].cl, vecs[i].we, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err,
                   $sformatf("vec%0d", i));
        end
        chk("vec_err_cnt", 64'(err_cnt), 64'd0);

        // Random traffic against the scalar memory model
        model_mem = 32'h0;
        for (int i = 0; i < 40; i++) begin
            cl = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            er = we ? wd : model_mem;
            do_txn(cl, we, wd, er, 1'b0, $sformatf("rnd%0d", i));
            if (we) model_mem = wd;
        end

        // Forced read-back mismatches and counter saturation
        force_bad = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 300; i++) begin
            do_txn(1'b0, 1'b1, 32'h1, 32'hDEAD_BEEF, 1'b1, $sformatf("bad%0d", i));
            n_bad++;
            exp_cnt = (n_bad > 255) ? 255 : n_bad;
            if (n_bad == 1 || n_bad == 254 || n_bad == 255 || n_bad == 256 || n_bad == 300)
                chk($sformatf("err_cnt_after_%0d", n_bad), 64'(err_cnt), 64'(exp_cnt));
        end
        force_bad = 1'b0;

        // Reset while in VERIFY of a B write
        @(negedge clk);
        b_req = 1; b_we = 1; b_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rstv_in_verify", 64'({ram_ce, ram_ce2, ram_we3}), 64'b010);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        b_req = 0;
        chk("rstv_strobes", 64'({ram_ce, ram_we, ram_ce3, ram_we3, ram_ce2}), 64'd0);
        chk("rstv_no_ack", 64'({a_ack, b_ack, verify_err}), 64'd0);
        chk("rstv_err_cnt", 64'(err_cnt), 64'd0);
        chk("rstv_ram_kept", 64'(mem), 64'hCAFE_F00D);
        edges = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (b_ack) edges++;
        end
        chk("rstv_no_late_ack", 64'(edges), 64'd0);
        do_txn(1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, "post_rst_read");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
